dmem_pipe: RTL and testbench
============================

DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, word-address width.
REQ-003 Parameter DEPTH, default 1024, number of words; SHALL satisfy 1 <= DEPTH <= 2^ADDR_W.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req  in  1  access request, qualified by ready.
REQ-007 ready  out  1  block accepts a request this cycle.
REQ-008 a  in  ADDR_W  word address.
REQ-009 we  in  1  1 = write, 0 = read.
REQ-010 be  in  DATA_W/8  byte enables for writes; bit i covers wd[8i+7:8i].
REQ-011 wd  in  DATA_W  write data.
REQ-012 rd  out  DATA_W  registered read data.
REQ-013 rvalid  out  1  one-cycle pulse: rd holds data for the read accepted the previous cycle.
REQ-014 oob  out  1  one-cycle pulse: the access accepted the previous cycle had a >= DEPTH.
REQ-015 perr  out  1  sticky parity error; present only with DMEM_PARITY_EN.

Function
REQ-016 The block SHALL have a two-state machine: CLEAR and RUN.
REQ-017 In CLEAR, a counter SHALL walk 0..DEPTH-1, writing all-zero words (and zero parity) at one word per cycle; ready = 0.
REQ-018 CLEAR -> RUN SHALL occur on the cycle after word DEPTH-1 is written, so ready rises exactly DEPTH cycles after rst deasserts.
REQ-019 In RUN, ready SHALL be 1 and a request SHALL be accepted when req && ready.
REQ-020 Accepted write with a < DEPTH: on that rising edge, update only the bytes whose be bit is 1; be = 0 leaves the word unchanged.
REQ-021 Accepted read with a < DEPTH: rd = mem[a] and rvalid = 1 on the following cycle (latency 1).
REQ-022 A read of an address written on the preceding cycle SHALL return the new data; a write and a read are never accepted in the same cycle.
REQ-023 Accepted access with a >= DEPTH: the write is dropped; a read returns rd = 0 with rvalid = 1; oob = 1 the next cycle in both cases.
REQ-024 When rvalid = 0, rd SHALL hold its last value.
REQ-025 req is ignored while ready = 0; requests dropped in CLEAR SHALL NOT be queued.
REQ-026 Back-to-back accepted reads SHALL give one rvalid pulse per read, in order, with no bubbles.

Reset
REQ-027 On rst = 1 at a clock edge: state = CLEAR, counter = 0, ready = 0, rvalid = 0, oob = 0, rd = 0, perr = 0.
REQ-028 rst asserted mid-CLEAR or mid-RUN SHALL abort any pending read response (no rvalid) and restart CLEAR from word 0.

Configuration
REQ-029 Macro DMEM_PARITY_EN: when defined, each word SHALL store one even-parity bit over DATA_W bits, recomputed on every write after byte merging.
REQ-030 With DMEM_PARITY_EN, a read with a < DEPTH whose stored parity mismatches SHALL set perr = 1 together with rvalid; perr clears only on rst.
REQ-031 Without DMEM_PARITY_EN: no parity storage, no perr port, and identical behaviour otherwise.

Structure
REQ-032 State encoding (CLEAR, RUN) and the DATA_W/8 byte-count helper SHALL live in the shared definitions package used by the datapath memories.
REQ-033 The storage array plus byte-merge logic SHALL be one sub-module, dmem_array; the state machine, counter and response registers stay in dmem_pipe.

Verification
REQ-034 DEPTH=16: deassert rst -> ready = 0 for 16 cycles, then 1; reads of words 0..15 all return 0.
REQ-035 Write a=3, wd=32'hA1B2C3D4, be=4'hF; then write a=3, wd=32'h00000055, be=4'b0001; read a=3 -> one cycle later rvalid = 1, rd = 32'hA1B2C355.
REQ-036 Reads to a=1,2,3 on consecutive cycles after preloading 1,2,3 -> rvalid high for 3 consecutive cycles, rd = 1, 2, 3.
REQ-037 DEPTH=16: read a=20 -> rd = 0, rvalid = 1, oob = 1; write a=20 -> memory unchanged, oob = 1.
REQ-038 Accept a read at a=5, assert rst the next edge -> no rvalid; ready = 0 for 16 cycles; word 5 reads 0 afterwards.
REQ-039 DMEM_PARITY_EN: write a=2, force-flip one stored data bit via hierarchical access, read a=2 -> perr = 1 with rvalid and stays 1 until rst.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory pipeline: controller states and sizing helpers.
package dmem_pkg;

   typedef enum logic {StClear, StRun} dmem_state_e;

   function automatic int unsigned byte_cnt(input int unsigned data_w);
      return data_w / 8;
   endfunction

   // Index width for a word array; never zero, even for a single-word memory.
   function automatic int unsigned idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with byte-enable merge and asynchronous read port.
// With DMEM_PARITY_EN each word also keeps an even-parity bit over the merged data.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic                            clk,
   input  logic                            wen,
   input  logic [idx_w(DEPTH)-1:0]         waddr,
   input  logic [byte_cnt(DATA_W)-1:0]     wbe,
   input  logic [DATA_W-1:0]               wdata,
   input  logic [idx_w(DEPTH)-1:0]         raddr,
   output logic [DATA_W-1:0]               rdata
`ifdef DMEM_PARITY_EN
   ,
   output logic                            rpar_err
`endif
);

   localparam int unsigned NB = byte_cnt(DATA_W);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] merged;

   always_comb begin
      merged = mem_q[waddr];
      for (int unsigned i = 0; i < NB; i++) begin
         if (wbe[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (wen) mem_q[waddr] <= merged;
   end

   assign rdata = mem_q[raddr];

`ifdef DMEM_PARITY_EN
   logic par_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) par_q[waddr] <= ^merged;
   end

   assign rpar_err = par_q[raddr] != (^mem_q[raddr]);
`endif

endmodule

// File: rtl/dmem_pipe.sv
// Data memory with power-up clear sweep, byte-enabled writes and one-cycle registered reads.
// Optional DMEM_PARITY_EN adds per-word parity and a sticky perr output.
module dmem_pipe
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req,
   output logic                        ready,
   input  logic [ADDR_W-1:0]           a,
   input  logic                        we,
   input  logic [byte_cnt(DATA_W)-1:0] be,
   input  logic [DATA_W-1:0]           wd,
   output logic [DATA_W-1:0]           rd,
   output logic                        rvalid,
   output logic                        oob
`ifdef DMEM_PARITY_EN
   ,
   output logic                        perr
`endif
);

   localparam int unsigned IDX_W = idx_w(DEPTH);
   localparam int unsigned NB    = byte_cnt(DATA_W);
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

   dmem_state_e state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic              rvalid_q, rvalid_d;
   logic              oob_q, oob_d;
   logic              perr_q, perr_d;

   logic              in_range;
   logic              arr_we;
   logic [IDX_W-1:0]  arr_waddr;
   logic [NB-1:0]     arr_be;
   logic [DATA_W-1:0] arr_wd;
   logic [DATA_W-1:0] arr_rdata;
   logic              arr_perr;

   assign in_range = {1'b0, a} < (ADDR_W + 1)'(DEPTH);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready     = 1'b0;
      arr_we    = 1'b0;
      arr_waddr = a[IDX_W-1:0];
      arr_be    = be;
      arr_wd    = wd;
      unique case (state_q)
         StClear: begin
            arr_we    = 1'b1;
            arr_waddr = cnt_q;
            arr_be    = '1;
            arr_wd    = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LastIdx) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun: begin
            ready  = 1'b1;
            arr_we = req && we && in_range;
         end
         default: state_d = StClear;
      endcase
   end

   // Out-of-range reads return zero; rd only moves on an accepted read.
   always_comb begin
      rvalid_d = 1'b0;
      oob_d    = 1'b0;
      rd_d     = rd_q;
      perr_d   = perr_q;
      if (state_q == StRun && req) begin
         oob_d = !in_range;
         if (!we) begin
            rvalid_d = 1'b1;
            rd_d     = in_range ? arr_rdata : '0;
            perr_d   = perr_q | (in_range & arr_perr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StClear;
         cnt_q    <= '0;
         rd_q     <= '0;
         rvalid_q <= 1'b0;
         oob_q    <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         rvalid_q <= rvalid_d;
         oob_q    <= oob_d;
         perr_q   <= perr_d;
      end
   end

   dmem_array #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_array (
      .clk     (clk),
      .wen     (arr_we),
      .waddr   (arr_waddr),
      .wbe     (arr_be),
      .wdata   (arr_wd),
      .raddr   (a[IDX_W-1:0]),
      .rdata   (arr_rdata)
`ifdef DMEM_PARITY_EN
      ,
      .rpar_err(arr_perr)
`endif
   );

`ifdef DMEM_PARITY_EN
   assign perr = perr_q;
`else
   assign arr_perr = 1'b0;
   logic unused_perr;
   assign unused_perr = perr_q;
`endif

   assign rd     = rd_q;
   assign rvalid = rvalid_q;
   assign oob    = oob_q;

endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe at DEPTH=16; parity checks compile in with DMEM_PARITY_EN.
module tb_dmem_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        ready;
   logic [15:0] a;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        rvalid;
   logic        oob;
`ifdef DMEM_PARITY_EN
   logic        perr;
`endif

   always #5 clk = ~clk;

   dmem_pipe #(
      .DATA_W(32),
      .ADDR_W(16),
      .DEPTH (16)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .ready (ready),
      .a     (a),
      .we    (we),
      .be    (be),
      .wd    (wd),
      .rd    (rd),
      .rvalid(rvalid),
      .oob   (oob)
`ifdef DMEM_PARITY_EN
      ,
      .perr  (perr)
`endif
   );

   typedef struct packed {
      logic        rv;
      logic        oob;
      logic [31:0] rd;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (rvalid === 1'b1 || oob === 1'b1) begin
         if (q.size() == 0) begin
            chk("mon_unexpected", {30'b0, rvalid, oob}, 32'h0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("mon_rvalid", {31'b0, rvalid}, {31'b0, e.rv});
            chk("mon_oob", {31'b0, oob}, {31'b0, e.oob});
            if (e.rv) chk("mon_rd", rd, e.rd);
         end
      end
   end

   task automatic do_write(input logic [15:0] addr, input logic [3:0] bev,
                           input logic [31:0] data);
      req = 1'b1; we = 1'b1; a = addr; be = bev; wd = data;
      if (addr >= 16) q.push_back('{rv: 1'b0, oob: 1'b1, rd: 32'h0});
      @(posedge clk); #1;
      req = 1'b0; we = 1'b0;
   endtask

   task automatic do_read(input logic [15:0] addr, input logic [31:0] exp_rd);
      req = 1'b1; we = 1'b0; a = addr; be = 4'h0; wd = 32'h0;
      q.push_back('{rv: 1'b1, oob: (addr >= 16), rd: exp_rd});
      @(posedge clk); #1;
      req = 1'b0;
      chk("read_latency", {31'b0, rvalid}, 32'h1);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   int n;

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; a = '0; be = '0; wd = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, ready}, 32'h0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
      chk("rst_oob", {31'b0, oob}, 32'h0);
      chk("rst_rd", rd, 32'h0);
`ifdef DMEM_PARITY_EN
      chk("rst_perr", {31'b0, perr}, 32'h0);
`endif
      rst = 1'b0;
      wait_ready(n);
      chk("clear_len", n, 32'd16);

      for (int i = 0; i < 16; i++) do_read(16'(i), 32'h0);

      // Byte-merge and read-after-write
      do_write(16'd3, 4'hF, 32'hA1B2C3D4);
      do_write(16'd3, 4'b0001, 32'h00000055);
      do_read(16'd3, 32'hA1B2C355);
      do_write(16'd3, 4'h0, 32'hFFFFFFFF);
      do_read(16'd3, 32'hA1B2C355);
      @(posedge clk); #1;
      chk("rd_hold", rd, 32'hA1B2C355);
      chk("idle_rvalid", {31'b0, rvalid}, 32'h0);

      // Back-to-back reads
      do_write(16'd1, 4'hF, 32'd1);
      do_write(16'd2, 4'hF, 32'd2);
      do_write(16'd3, 4'hF, 32'd3);
      do_read(16'd1, 32'd1);
      do_read(16'd2, 32'd2);
      do_read(16'd3, 32'd3);

      // Out-of-range accesses; address 20 must not alias onto word 4
      do_read(16'd20, 32'h0);
      do_write(16'd20, 4'hF, 32'hFFFFFFFF);
      do_read(16'd4, 32'h0);
      do_read(16'd3, 32'd3);
      do_write(16'hFFFF, 4'hF, 32'hDEADBEEF);
      do_read(16'd15, 32'h0);

      // Reset aborts a read and restarts the clear sweep
      do_write(16'd5, 4'hF, 32'h5A5A5A5A);
      do_write(16'd2, 4'hF, 32'h12345678);
      do_read(16'd5, 32'h5A5A5A5A);
      req = 1'b1; we = 1'b0; a = 16'd5; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_rvalid", {31'b0, rvalid}, 32'h0);
      // Writes during the sweep must be ignored
      req = 1'b1; we = 1'b1; a = 16'd2; be = 4'hF; wd = 32'hCAFEF00D;
      for (int i = 0; i < 5; i++) begin
         chk("clear_not_ready", {31'b0, ready}, 32'h0);
         @(posedge clk); #1;
      end
      req = 1'b0; we = 1'b0;
      wait_ready(n);
      chk("clear_len2", n + 5, 32'd16);
      do_read(16'd5, 32'h0);
      do_read(16'd2, 32'h0);

`ifdef DMEM_PARITY_EN
      do_write(16'd2, 4'hF, 32'h0000000F);
      dut.u_array.mem_q[2][0] = ~dut.u_array.mem_q[2][0];
      do_read(16'd2, 32'h0000000E);
      chk("perr_set", {31'b0, perr}, 32'h1);
      do_read(16'd3, 32'h0);
      chk("perr_sticky", {31'b0, perr}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("perr_clear", {31'b0, perr}, 32'h0);
      wait_ready(n);
      chk("clear_len3", n, 32'd16);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
